caesar_scroll_display: RTL and testbench
========================================

// Module: caesar_scroll_display
// PURPOSE
//  Downstream consumer of CaesarEncoder's 5-bit code (S4..S0). Buffers encoded symbols in a
//  circular store and drives a DIGITS-wide multiplexed 7-segment display. If more symbols are
//  stored than digits exist, the window scrolls through them.
// PARAMETERS
//  DEPTH       8  symbol buffer entries (power of 2)
//  DIGITS      4  physical display digits
//  SCROLL_DIV  4  clock cycles per one-position scroll step (>=1)
// PORTS
//  ready      in   1                  clock, rising-edge; same net that clocks CaesarEncoder
//  reset      in   1                  synchronous, active-high
//  clr        in   1                  empty the buffer (synchronous)
//  sym_valid  in   1                  sym carries a new encoded symbol this cycle
//  sym        in   5                  encoded symbol, sym[4]=S4 .. sym[0]=S0
//  sym_ready  out  1                  buffer can accept (= !full)
//  seg        out  7                  segments, seg[0]=c0=a .. seg[6]=c6=g; 1 = lit
//  dig_en     out  DIGITS             one-hot digit enable, active-high
//  count      out  $clog2(DEPTH+1)    symbols stored
//  full       out  1                  count==DEPTH
//  empty      out  1                  count==0
// BEHAVIOUR
//  - One clock (ready); reset is synchronous and active-high. All state updates on the rising edge.
//  - Reset values: seg=0, dig_en=0, count=0, empty=1, full=0, sym_ready=1, state=IDLE,
//    scroll offset=0, divider=0, digit index=0.
//  - Write: a symbol is stored when sym_valid && sym_ready. It goes to wr_ptr, then wr_ptr wraps
//    mod DEPTH and count is incremented. When full, sym_ready=0 and writes are dropped silently.
//  - clr: sets count=0, wr_ptr=0, offset=0, divider=0. Outputs blank on the next cycle.
//    clr beats a simultaneous write; reset beats clr.
//  - States, evaluated from the registered count:
//    IDLE    count==0      : seg=0, dig_en=0.
//    HOLD    1..DIGITS     : static window, offset=0, divider held at 0.
//    SCROLL  count>DIGITS  : divider counts 0..SCROLL_DIV-1; at terminal count, offset <= (offset+1)
//                            mod count. Offset wraps to 0 after count steps.
//    Transitions follow count. Leaving SCROLL (only via clr or reset) resets offset and divider.
//  - Digit mux: the digit index i advances 0..DIGITS-1 every cycle and wraps. In HOLD/SCROLL:
//    dig_en=1<<i; seg=decode(buf[(oldest+offset+i) mod count]) if i<count, else seg=0.
//    oldest=(wr_ptr-count) mod DEPTH.
//  - Output latency: seg and dig_en are registered. They reflect the index, state and buffer
//    contents sampled on the previous edge. A written symbol first appears 1 cycle after the
//    edge that stores it.
//  - A write during SCROLL keeps the current offset (the new count is larger), so the window
//    does not jump.
//  - decode: 0..15 give the standard hex glyph (0=0111111, 3=1001111, 4=1100110, A=1110111).
//    16..31 give blank (0000000).
// STRUCTURE
//  - Package caesar_pkg: glyph constants SEG_0..SEG_F and SEG_BLANK; state encoding
//    IDLE/HOLD/SCROLL; width localparams for the 5-bit symbol and 7-bit segment vectors.
//  - Sub-module caesar_seg_decode (combinational, 5-bit -> 7-bit). It is shareable with the
//    existing display path.
//  - Top level: buffer RAM plus pointers, state/divider/offset logic, digit-index counter, and
//    the output register.
// TESTING (defaults DEPTH=8, DIGITS=4, SCROLL_DIV=4)
//  1. Hold reset for 2 edges -> seg=0, dig_en=0, count=0, empty=1, full=0, sym_ready=1.
//  2. Write 3, then 4 -> count=2, HOLD. Over 4 cycles: dig_en 0001/0010/0100/1000 with
//     seg 1001111/1100110/0000000/0000000, repeating.
//  3. Write 3..10 (8 symbols) -> full=1, sym_ready=0. A 9th write (sym=11) is ignored:
//     count=8, contents unchanged.
//  4. Write 5 symbols -> SCROLL. Offset steps 0->1 after 4 cycles and returns to 0 after 20
//     cycles. Digit 0 shows symbol[offset] each step.
//  5. Assert clr and sym_valid (sym=7) in the same cycle with count=5 -> next cycle count=0,
//     empty=1, seg=0, dig_en=0.
//  6. Assert reset in mid-SCROLL, with a write pending -> next edge all reset values; the write
//     is not stored.

Source files
------------

// File: rtl/caesar_pkg.sv
// Shared types and glyph constants for the Caesar symbol display path.
// Segment vectors are ordered g..a (bit 6 = g, bit 0 = a).
package caesar_pkg;

  localparam int SYM_W = 5;
  localparam int SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_0 = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_1 = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_2 = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_3 = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_4 = 7'b1100110;
  localparam logic [SEG_W-1:0] SEG_5 = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_6 = 7'b1111101;
  localparam logic [SEG_W-1:0] SEG_7 = 7'b0000111;
  localparam logic [SEG_W-1:0] SEG_8 = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9 = 7'b1101111;
  localparam logic [SEG_W-1:0] SEG_A = 7'b1110111;
  localparam logic [SEG_W-1:0] SEG_B = 7'b1111100;
  localparam logic [SEG_W-1:0] SEG_C = 7'b0111001;
  localparam logic [SEG_W-1:0] SEG_D = 7'b1011110;
  localparam logic [SEG_W-1:0] SEG_E = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_F = 7'b1110001;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    SCROLL = 2'd2
  } state_e;

endpackage

// File: rtl/caesar_seg_decode.sv
// Symbol to 7-segment glyph decoder.
// Codes 16..31 have no glyph and render blank.
module caesar_seg_decode
  import caesar_pkg::*;
(
  input  logic [SYM_W-1:0] sym,
  output logic [SEG_W-1:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (sym)
      5'd0:  seg = SEG_0;
      5'd1:  seg = SEG_1;
      5'd2:  seg = SEG_2;
      5'd3:  seg = SEG_3;
      5'd4:  seg = SEG_4;
      5'd5:  seg = SEG_5;
      5'd6:  seg = SEG_6;
      5'd7:  seg = SEG_7;
      5'd8:  seg = SEG_8;
      5'd9:  seg = SEG_9;
      5'd10: seg = SEG_A;
      5'd11: seg = SEG_B;
      5'd12: seg = SEG_C;
      5'd13: seg = SEG_D;
      5'd14: seg = SEG_E;
      5'd15: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/caesar_scroll_display.sv
// Circular symbol store driving a multiplexed 7-segment display;
// the window scrolls when more symbols are held than digits exist.
module caesar_scroll_display
  import caesar_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int DIGITS     = 4,
  parameter int SCROLL_DIV = 4
) (
  input  logic                       ready,
  input  logic                       reset,
  input  logic                       clr,
  input  logic                       sym_valid,
  input  logic [SYM_W-1:0]           sym,
  output logic                       sym_ready,
  output logic [SEG_W-1:0]           seg,
  output logic [DIGITS-1:0]          dig_en,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

  logic [SYM_W-1:0]  mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     count_d;
  state_e            state_q;
  state_e            state_d;
  logic [CW-1:0]     off_q;
  logic [DW-1:0]     div_q;
  logic [IW-1:0]     idx_q;
  logic [SEG_W-1:0]  seg_q;
  logic [DIGITS-1:0] dig_q;

  logic              wr_en;
  logic [AW-1:0]     oldest;
  logic [CW:0]       pos_sum;
  logic [CW:0]       pos;
  logic [AW-1:0]     rd_addr;
  logic [SEG_W-1:0]  glyph;
  logic [SEG_W-1:0]  seg_d;
  logic [DIGITS-1:0] dig_d;
  logic              lit;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign sym_ready = !full;
  assign count     = count_q;
  assign seg       = seg_q;
  assign dig_en    = dig_q;
  assign wr_en     = sym_valid && sym_ready && !clr;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (wr_en) begin
      count_d = count_q + 1'b1;
    end
  end

  always_comb begin
    state_d = IDLE;
    unique case (1'b1)
      (count_d == '0):            state_d = IDLE;
      (count_d != '0 &&
       int'(count_d) <= DIGITS):  state_d = HOLD;
      (int'(count_d) > DIGITS):   state_d = SCROLL;
      default:                    state_d = IDLE;
    endcase
  end

  // Logical position (offset + digit) wraps at count, then maps onto the ring.
  always_comb begin
    oldest  = wr_ptr - AW'(count_q);
    pos_sum = {1'b0, off_q} + (CW + 1)'(idx_q);
    pos     = pos_sum;
    if (pos_sum >= {1'b0, count_q}) begin
      pos = pos_sum - {1'b0, count_q};
    end
    rd_addr = oldest + AW'(pos);
  end

  caesar_seg_decode u_dec (
    .sym (mem[rd_addr]),
    .seg (glyph)
  );

  always_comb begin
    seg_d = SEG_BLANK;
    dig_d = '0;
    lit   = (state_q != IDLE) && (CW'(idx_q) < count_q);
    if (state_q != IDLE) begin
      dig_d = DIGITS'(1) << idx_q;
    end
    if (lit) begin
      seg_d = glyph;
    end
  end

  always_ff @(posedge ready) begin
    if (wr_en && !reset) begin
      mem[wr_ptr] <= sym;
    end
  end

  always_ff @(posedge ready) begin
    if (reset) begin
      wr_ptr  <= '0;
      count_q <= '0;
      state_q <= IDLE;
      off_q   <= '0;
      div_q   <= '0;
      idx_q   <= '0;
      seg_q   <= SEG_BLANK;
      dig_q   <= '0;
    end else begin
      count_q <= count_d;
      state_q <= state_d;
      if (idx_q == IW'(DIGITS - 1)) begin
        idx_q <= '0;
      end else begin
        idx_q <= idx_q + 1'b1;
      end
      if (clr) begin
        wr_ptr <= '0;
      end else if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (clr || state_q != SCROLL) begin
        off_q <= '0;
        div_q <= '0;
      end else if (div_q == DW'(SCROLL_DIV - 1)) begin
        div_q <= '0;
        if (off_q + 1'b1 >= count_q) begin
          off_q <= '0;
        end else begin
          off_q <= off_q + 1'b1;
        end
      end else begin
        div_q <= div_q + 1'b1;
      end
      if (clr) begin
        seg_q <= SEG_BLANK;
        dig_q <= '0;
      end else begin
        seg_q <= seg_d;
        dig_q <= dig_d;
      end
    end
  end

endmodule

// File: tb/tb_caesar_scroll_display.sv
// Scoreboard bench for caesar_scroll_display against a queue model.
// Expected outputs are queued at drive time, popped after the edge.
module tb_caesar_scroll_display;

  localparam int DEPTH  = 8;
  localparam int DIGITS = 4;
  localparam int SD     = 4;

  logic       ready = 1'b0;
  logic       reset;
  logic       clr;
  logic       sym_valid;
  logic [4:0] sym;
  logic       sym_ready;
  logic [6:0] seg;
  logic [3:0] dig_en;
  logic [3:0] count;
  logic       full;
  logic       empty;

  caesar_scroll_display #(
    .DEPTH      (DEPTH),
    .DIGITS     (DIGITS),
    .SCROLL_DIV (SD)
  ) dut (
    .ready     (ready),
    .reset     (reset),
    .clr       (clr),
    .sym_valid (sym_valid),
    .sym       (sym),
    .sym_ready (sym_ready),
    .seg       (seg),
    .dig_en    (dig_en),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always #5 ready = ~ready;

  typedef struct {
    int seg;
    int dig;
    int cnt;
  } exp_t;

  exp_t sb[$];
  int   mq[$];
  int   m_off;
  int   m_div;
  int   m_idx;
  int   checks = 0;
  int   errors = 0;

  logic [6:0] glyph_tab [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic int gl(input int s);
    return (s < 16) ? int'(glyph_tab[s]) : 0;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit c,
                      input bit v, input int s);
    exp_t e;
    int   cnt;
    cnt       = mq.size();
    reset     = r;
    clr       = c;
    sym_valid = v;
    sym       = 5'(s);
    if (r) begin
      e = '{0, 0, 0};
      mq.delete();
      m_off = 0;
      m_div = 0;
      m_idx = 0;
    end else begin
      if (c || cnt == 0) begin
        e.seg = 0;
        e.dig = 0;
      end else begin
        e.dig = 1 << m_idx;
        e.seg = (m_idx < cnt) ? gl(mq[(m_off + m_idx) % cnt]) : 0;
      end
      m_idx = (m_idx + 1) % DIGITS;
      if (c) begin
        mq.delete();
        m_off = 0;
        m_div = 0;
      end else begin
        if (cnt > DIGITS) begin
          if (m_div == SD - 1) begin
            m_div = 0;
            m_off = (m_off + 1) % cnt;
          end else begin
            m_div++;
          end
        end else begin
          m_off = 0;
          m_div = 0;
        end
        if (v && cnt < DEPTH) mq.push_back(s);
      end
      e.cnt = mq.size();
    end
    sb.push_back(e);
    @(posedge ready);
    @(negedge ready);
    e = sb.pop_front();
    chk("seg", 32'(seg), 32'(e.seg));
    chk("dig_en", 32'(dig_en), 32'(e.dig));
    chk("count", 32'(count), 32'(e.cnt));
    chk("full", 32'(full), 32'(e.cnt == DEPTH));
    chk("empty", 32'(empty), 32'(e.cnt == 0));
    chk("sym_ready", 32'(sym_ready), 32'(e.cnt != DEPTH));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  initial begin
    reset     = 1'b1;
    clr       = 1'b0;
    sym_valid = 1'b0;
    sym       = '0;
    m_off     = 0;
    m_div     = 0;
    m_idx     = 0;

    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("rst_seg", 32'(seg), 32'd0);
    chk("rst_cnt", 32'(count), 32'd0);

    step(0, 0, 1, 3);
    step(0, 0, 1, 4);
    idle(8);

    step(0, 1, 0, 0);
    for (int i = 3; i <= 10; i++) step(0, 0, 1, i);
    chk("full_flag", 32'(full), 32'd1);
    step(0, 0, 1, 11);
    chk("ovf_cnt", 32'(count), 32'd8);
    idle(40);

    step(0, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 12 + i);
    idle(24);
    step(0, 0, 1, 17);
    idle(12);

    step(0, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, i + 1);
    step(0, 1, 1, 7);
    chk("clr_empty", 32'(empty), 32'd1);
    chk("clr_dig", 32'(dig_en), 32'd0);
    idle(3);

    for (int i = 0; i < 6; i++) step(0, 0, 1, 20 + i);
    idle(9);
    step(1, 0, 1, 9);
    chk("rst_mid_cnt", 32'(count), 32'd0);
    idle(3);

    for (int i = 0; i < 300; i++) begin
      step(0, $urandom_range(0, 40) == 0,
           $urandom_range(0, 3) == 0,
           int'($urandom_range(0, 31)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
